// File: rtl/thermal_source_selector.sv
// Picks at most one thermal source and a heat/cool direction from live thresholds,
// debounces the choice over consecutive samples and inserts an all-off gap before engaging.
module thermal_source_selector #(
  parameter int DWELL_SAMPLES = 4,
  parameter int GAP_CYCLES    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic signed [7:0]  room_temp,
  input  logic        [15:0] solar_level,
  input  logic        [15:0] solar_th,
  input  logic signed [7:0]  solar_cooldown_th,
  input  logic signed [7:0]  solar_heatup_th,
  input  logic signed [7:0]  ambient_cooldown_th,
  input  logic signed [7:0]  ambient_heatup_th,
  input  logic signed [7:0]  geothermal_cooldown_th,
  input  logic signed [7:0]  geothermal_heatup_th,
  output logic               solar_en,
  output logic               ambient_en,
  output logic               geothermal_en,
  output logic               heat_mode,
  output logic        [1:0]  active_src,
  output logic               busy
);

  localparam int QW = $clog2(DWELL_SAMPLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [QW-1:0] DWELL_Q  = QW'(DWELL_SAMPLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_SOLAR = 2'd1;
  localparam logic [1:0] SRC_AMB   = 2'd2;
  localparam logic [1:0] SRC_GEO   = 2'd3;

  logic signed [7:0] cool_th [3];
  logic signed [7:0] heat_th [3];
  logic [2:0] avail, cool_hit, heat_hit;
  logic [1:0] cand_src;
  logic       cand_heat;

  assign cool_th[0] = solar_cooldown_th;
  assign cool_th[1] = ambient_cooldown_th;
  assign cool_th[2] = geothermal_cooldown_th;
  assign heat_th[0] = solar_heatup_th;
  assign heat_th[1] = ambient_heatup_th;
  assign heat_th[2] = geothermal_heatup_th;
  assign avail      = {2'b11, solar_level >= solar_th};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cmp
      assign cool_hit[gi] = avail[gi] && (room_temp >= cool_th[gi]);
      assign heat_hit[gi] = avail[gi] && (room_temp <= heat_th[gi]);
    end
  endgenerate

  // Any cooling match outranks every heating match; within a direction solar wins.
  always_comb begin
    cand_src  = SRC_NONE;
    cand_heat = 1'b0;
    if (cool_hit[0])      cand_src = SRC_SOLAR;
    else if (cool_hit[1]) cand_src = SRC_AMB;
    else if (cool_hit[2]) cand_src = SRC_GEO;
    else if (heat_hit[0]) begin cand_src = SRC_SOLAR; cand_heat = 1'b1; end
    else if (heat_hit[1]) begin cand_src = SRC_AMB;   cand_heat = 1'b1; end
    else if (heat_hit[2]) begin cand_src = SRC_GEO;   cand_heat = 1'b1; end
  end

  logic [1:0]    state_reg, state_next;
  logic [1:0]    cur_src_reg, cur_src_next, pend_src_reg, pend_src_next;
  logic          cur_heat_reg, cur_heat_next, pend_heat_reg, pend_heat_next;
  logic [QW-1:0] qual_reg, qual_next, cnt_inc;
  logic [GW-1:0] gap_reg, gap_next;

  always_comb begin
    state_next     = state_reg;
    cur_src_next   = cur_src_reg;
    cur_heat_next  = cur_heat_reg;
    pend_src_next  = pend_src_reg;
    pend_heat_next = pend_heat_reg;
    qual_next      = qual_reg;
    gap_next       = gap_reg;
    cnt_inc        = '0;
    if (state_reg == S_GAP) begin
      qual_next = '0;
      if (gap_reg == '0) begin
        cur_src_next  = pend_src_reg;
        cur_heat_next = pend_heat_reg;
        state_next    = S_RUN;
      end else begin
        gap_next = gap_reg - 1'b1;
      end
    end else if (sample_valid) begin
      if (cand_src == cur_src_reg && cand_heat == cur_heat_reg) begin
        qual_next = '0;
      end else begin
        if (cand_src == pend_src_reg && cand_heat == pend_heat_reg && qual_reg != '0) begin
          cnt_inc = qual_reg + 1'b1;
        end else begin
          pend_src_next  = cand_src;
          pend_heat_next = cand_heat;
          cnt_inc        = QW'(1);
        end
        // On commit the pending choice equals the current candidate.
        if (cnt_inc == DWELL_Q) begin
          qual_next = '0;
          if (cand_src == SRC_NONE) begin
            cur_src_next  = SRC_NONE;
            cur_heat_next = 1'b0;
            state_next    = S_IDLE;
          end else begin
            state_next = S_GAP;
            gap_next   = GAP_LOAD;
          end
        end else begin
          qual_next = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cur_src_reg   <= SRC_NONE;
      cur_heat_reg  <= 1'b0;
      pend_src_reg  <= SRC_NONE;
      pend_heat_reg <= 1'b0;
      qual_reg      <= '0;
      gap_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cur_src_reg   <= cur_src_next;
      cur_heat_reg  <= cur_heat_next;
      pend_src_reg  <= pend_src_next;
      pend_heat_reg <= pend_heat_next;
      qual_reg      <= qual_next;
      gap_reg       <= gap_next;
    end
  end

  logic       running;
  logic [2:0] en;

  assign running = (state_reg == S_RUN);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_en
      assign en[gi] = running && (cur_src_reg == 2'(gi + 1));
    end
  endgenerate

  assign solar_en      = en[0];
  assign ambient_en    = en[1];
  assign geothermal_en = en[2];
  assign heat_mode     = running & cur_heat_reg;
  assign active_src    = running ? cur_src_reg : SRC_NONE;
  assign busy          = (state_reg == S_GAP);

endmodule
